// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Optional perf counters (perf_bubbles, perf_flushes) are enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_dst,
  input  logic               id_uses_rt,
  input  logic [3:0]         id_alu_ctrl,
  input  logic               id_sign,
  input  logic               id_alusrc_a,
  input  logic               id_alusrc_b,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_dst,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0]  wb_fwd_data,
  output logic               id_stall_req,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  alu_in_1,
  output logic [DATA_W-1:0]  alu_in_2,
  output logic [3:0]         alu_ctrl,
  output logic               alu_sign,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_dst,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_flushes
`endif
);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic [4:0]         shamt;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] dst;
    logic [3:0]         alu_ctrl;
    logic               sign;
    logic               alusrc_a;
    logic               alusrc_b;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d;
  logic     load_use;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RADDR_W-1:0] r,
    input logic [DATA_W-1:0]  rf_data,
    input logic               m_we,
    input logic [RADDR_W-1:0] m_dst,
    input logic [DATA_W-1:0]  m_data,
    input logic               w_we,
    input logic [RADDR_W-1:0] w_dst,
    input logic [DATA_W-1:0]  w_data
  );
    logic [DATA_W-1:0] v;
    if (r == '0)                     v = '0;
    else if (m_we && (m_dst == r))   v = m_data;
    else if (w_we && (w_dst == r))   v = w_data;
    else                             v = rf_data;
    return v;
  endfunction

  // The load in EX cannot be forwarded to an ID consumer until it reaches MEM.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.dst != '0) & id_valid &
               ((ex_q.dst == id_rs) | (id_uses_rt & (ex_q.dst == id_rt)));
  end

  assign id_stall_req = load_use & ~flush;

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.pc         = id_pc;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.shamt      = id_shamt;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dst        = id_dst;
      ex_d.alu_ctrl   = id_alu_ctrl;
      ex_d.sign       = id_sign;
      ex_d.alusrc_a   = id_alusrc_a;
      ex_d.alusrc_b   = id_alusrc_b;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Forwarding is evaluated from live MEM/WB inputs so held operands track them.
  always_comb begin
    fwd_rs = fwd_sel(ex_q.rs, ex_q.rs_data, mem_reg_write, mem_dst, mem_fwd_data,
                     wb_reg_write, wb_dst, wb_fwd_data);
    fwd_rt = fwd_sel(ex_q.rt, ex_q.rt_data, mem_reg_write, mem_dst, mem_fwd_data,
                     wb_reg_write, wb_dst, wb_fwd_data);
  end

  always_comb begin
    alu_in_1      = ex_q.alusrc_a ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
    alu_in_2      = ex_q.alusrc_b ? ex_q.imm : fwd_rt;
    ex_store_data = fwd_rt;
    alu_ctrl      = ex_q.alu_ctrl;
    alu_sign      = ex_q.sign;
    ex_valid      = ex_q.valid;
    ex_pc         = ex_q.pc;
    ex_dst        = ex_q.dst;
    ex_reg_write  = ex_q.reg_write  & ex_q.valid;
    ex_mem_read   = ex_q.mem_read   & ex_q.valid;
    ex_mem_write  = ex_q.mem_write  & ex_q.valid;
    ex_mem_to_reg = ex_q.mem_to_reg & ex_q.valid;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (flush)                      perf_flushes_d = perf_flushes_q + 32'd1;
    else if (!stall && load_use)    perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`else
  // Counters absent in the default build.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expectations into a
// scoreboard queue tagged with a cycle number; a negedge monitor pops and compares.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
  logic        id_uses_rt;
  logic [3:0]  id_alu_ctrl;
  logic        id_sign, id_alusrc_a, id_alusrc_b;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_dst, wb_dst;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        id_stall_req, ex_valid;
  logic [31:0] ex_pc, alu_in_1, alu_in_2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        alu_sign;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  id_ex_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_uses_rt(id_uses_rt), .id_alu_ctrl(id_alu_ctrl), .id_sign(id_sign),
    .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_fwd_data(mem_fwd_data),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_fwd_data(wb_fwd_data),
    .id_stall_req(id_stall_req), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_ctrl(alu_ctrl),
    .alu_sign(alu_sign), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        valid;
    logic [31:0] a1, a2, sd, pc;
    logic [3:0]  ctrl;
    logic        sign;
    logic [4:0]  dst;
    logic [3:0]  cb;   // {reg_write, mem_read, mem_write, mem_to_reg}
    logic        sr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, exp);
    end
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s.stale got=cycle%0d want=cycle%0d", e.name, cyc, e.cyc);
      end else begin
        chk(e.name, "ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk(e.name, "alu_in_1", alu_in_1, e.a1);
        chk(e.name, "alu_in_2", alu_in_2, e.a2);
        chk(e.name, "store", ex_store_data, e.sd);
        chk(e.name, "ex_pc", ex_pc, e.pc);
        chk(e.name, "alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
        chk(e.name, "alu_sign", {31'd0, alu_sign}, {31'd0, e.sign});
        chk(e.name, "ex_dst", {27'd0, ex_dst}, {27'd0, e.dst});
        chk(e.name, "ctrl_bits",
            {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, e.cb});
        chk(e.name, "stall_req", {31'd0, id_stall_req}, {31'd0, e.sr});
      end
    end
  end

  task automatic push(string nm, logic v, logic [31:0] a1, logic [31:0] a2,
                      logic [31:0] sd, logic [31:0] pc, logic [3:0] ctrl, logic sign,
                      logic [4:0] dst, logic [3:0] cb, logic sr);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.valid = v; e.a1 = a1; e.a2 = a2; e.sd = sd;
    e.pc = pc; e.ctrl = ctrl; e.sign = sign; e.dst = dst; e.cb = cb; e.sr = sr;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_shamt = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_uses_rt = 0;
    id_alu_ctrl = 0; id_sign = 0; id_alusrc_a = 0; id_alusrc_b = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    stall = 0; flush = 0;
    mem_reg_write = 0; mem_dst = 0; mem_fwd_data = 0;
    wb_reg_write = 0; wb_dst = 0; wb_fwd_data = 0;
  endtask

  task automatic id_instr(logic [31:0] pc, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                          logic [31:0] rsd, logic [31:0] rtd, logic uses_rt,
                          logic [3:0] ctrl, logic [3:0] cb);
    id_valid = 1; id_pc = pc; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_uses_rt = uses_rt; id_alu_ctrl = ctrl;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = cb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    id_instr(32'h200, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 4'd3, 4'b1111);
    cycle();
    push("reset_1", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    cycle();
    reset = 0;
    idle();
    id_instr(32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b1, 4'd0, 4'b1000);
    push("reset_2", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // add $3,$1,$2 now in EX; next ID instruction reads $4/$5
    cycle();
    idle();
    id_instr(32'h104, 5'd4, 5'd5, 5'd6, 32'h99, 32'h55, 1'b1, 4'd1, 4'b1000);
    push("add", 1, 5, 7, 7, 32'h100, 0, 0, 3, 4'b1000, 0);

    cycle();
    idle();
    stall = 1;
    mem_reg_write = 1; mem_dst = 4; mem_fwd_data = 32'h11;
    wb_reg_write = 1;  wb_dst = 4;  wb_fwd_data = 32'h22;
    push("fwd_mem_pri", 1, 32'h11, 32'h55, 32'h55, 32'h104, 1, 0, 6, 4'b1000, 0);

    cycle();
    idle();
    wb_reg_write = 1; wb_dst = 4; wb_fwd_data = 32'h22;
    id_instr(32'h108, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 1'b1, 4'd2, 4'b1000);
    push("fwd_wb", 1, 32'h22, 32'h55, 32'h55, 32'h104, 1, 0, 6, 4'b1000, 0);

    // r0 is never forwarded; next ID is lw $8,4($1)
    cycle();
    idle();
    mem_reg_write = 1; mem_dst = 0; mem_fwd_data = 32'h11;
    wb_reg_write = 1;  wb_dst = 0;  wb_fwd_data = 32'h22;
    id_instr(32'h10C, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 1'b0, 4'd0, 4'b1101);
    id_imm = 32'd4; id_alusrc_b = 1;
    push("fwd_r0", 1, 0, 0, 0, 32'h108, 2, 0, 7, 4'b1000, 0);

    cycle();
    idle();
    id_instr(32'h110, 5'd8, 5'd1, 5'd9, 32'hBAD, 32'd3, 1'b1, 4'd1, 4'b1000);
    push("lw_ex", 1, 32'h1000, 4, 0, 32'h10C, 0, 0, 8, 4'b1101, 1);

    cycle();
    idle();
    id_instr(32'h110, 5'd8, 5'd1, 5'd9, 32'hBAD, 32'd3, 1'b1, 4'd1, 4'b1000);
    mem_reg_write = 1; mem_dst = 8; mem_fwd_data = 32'hABCD;
    push("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    cycle();
    idle();
    mem_reg_write = 1; mem_dst = 8; mem_fwd_data = 32'hABCD;
    id_instr(32'h114, 5'd2, 5'd3, 5'd10, 32'h50, 32'h60, 1'b1, 4'd5, 4'b1010);
    id_sign = 1; flush = 1; stall = 1;
    push("sub_fwd", 1, 32'hABCD, 3, 3, 32'h110, 1, 0, 9, 4'b1000, 0);

    cycle();
    idle();
    id_instr(32'h118, 5'd2, 5'd3, 5'd10, 32'h50, 32'h60, 1'b1, 4'd5, 4'b1010);
    id_sign = 1; id_imm = 32'h7;
    push("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    cycle();
    idle();
    id_instr(32'h1F0, 5'd9, 5'd9, 5'd9, 32'hDEAD, 32'hBEEF, 1'b1, 4'hF, 4'b1111);
    stall = 1;
    push("capture", 1, 32'h50, 32'h60, 32'h60, 32'h118, 5, 1, 10, 4'b1010, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i == 2) begin
        idle();
        id_instr(32'h11C, 5'd0, 5'd3, 5'd2, 32'h0, 32'h1, 1'b1, 4'd7, 4'b1000);
        id_shamt = 5'd4; id_alusrc_a = 1;
      end
      push($sformatf("hold_%0d", i), 1, 32'h50, 32'h60, 32'h60, 32'h118, 5, 1, 10,
           4'b1010, 0);
    end

    cycle();
    idle();
    id_instr(32'h120, 5'd0, 5'd4, 5'd4, 32'h0, 32'h0, 1'b0, 4'd0, 4'b1101);
    id_imm = 32'd8; id_alusrc_b = 1;
    push("sll", 1, 4, 1, 1, 32'h11C, 7, 0, 2, 4'b1000, 0);

    // lw $4 in EX with a $4 consumer in ID: stall dominates yet the request stays up
    cycle();
    idle();
    id_instr(32'h124, 5'd1, 5'd4, 5'd5, 32'd2, 32'd0, 1'b1, 4'd0, 4'b1000);
    stall = 1;
    push("lu_stall", 1, 0, 8, 0, 32'h120, 0, 0, 4, 4'b1101, 1);

    cycle();
    idle();
    id_instr(32'h124, 5'd1, 5'd4, 5'd5, 32'd2, 32'd0, 1'b1, 4'd0, 4'b1000);
    flush = 1;
    push("lu_flush", 1, 0, 8, 0, 32'h120, 0, 0, 4, 4'b1101, 0);

    cycle();
    idle();
    id_instr(32'h124, 5'd1, 5'd4, 5'd5, 32'd2, 32'd0, 1'b1, 4'd0, 4'b1000);
    push("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    cycle();
    idle();
    mem_reg_write = 1; mem_dst = 4; mem_fwd_data = 32'h77;
    push("add_rt_fwd", 1, 2, 32'h77, 32'h77, 32'h124, 0, 0, 5, 4'b1000, 0);

    cycle();
    cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
